bus_ciclo_8086: RTL and testbench
=================================

Name: bus_ciclo_8086

Overview:
- Bus-cycle controller directly downstream of the 20-bit physical address generator.
- Accepts one memory request per handshake: the 20-bit address, read/write, and byte/word size.
- Executes 8086-style T1-T2-T3-(TW)-T4 bus cycles on a demultiplexed 16-bit data bus.
- Splits word accesses at odd addresses into two byte cycles and returns read data with a one-cycle response pulse.

Parameters:
- TIMEOUT_CYC, 15: maximum consecutive wait-state (TW) cycles before abort. Used only when BUS_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  high only in IDLE; request is accepted when REQ_VALID and REQ_READY are both high.
- REQ_WR  in  1  1 = write, 0 = read.
- REQ_WORD  in  1  1 = 16-bit access, 0 = byte access.
- REQ_ADDR  in  20  physical address, taken from the address generator output.
- REQ_WDATA  in  16  write data; a byte write uses [7:0].
- RSP_VALID  out  1  one-cycle pulse when the request completes.
- RSP_RDATA  out  16  read data; byte reads are zero-extended.
- RSP_ERR  out  1  timeout abort flag, qualified by RSP_VALID.
- BUS_ADDR  out  20  bus address.
- BUS_BHE_N  out  1  high-byte enable, active-low.
- BUS_ALE  out  1  address latch enable.
- BUS_RD_N  out  1  read strobe, active-low.
- BUS_WR_N  out  1  write strobe, active-low.
- BUS_WDATA  out  16  write data.
- BUS_WDATA_OE  out  1  write data valid/drive enable.
- BUS_RDATA  in  16  read data from memory.
- BUS_READY  in  1  memory ready; sampled in T3 and TW.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - BUS_RD_N, BUS_WR_N and BUS_BHE_N go to 1.
  - BUS_ALE, BUS_WDATA_OE, RSP_VALID and RSP_ERR go to 0.
  - BUS_ADDR, BUS_WDATA and RSP_RDATA go to 0.
  - A request in flight when reset asserts is dropped and produces no response.
- States: IDLE, T1, T2, T3, TW, T4. All outputs are registered.
- IDLE: REQ_READY=1. On acceptance, latch the request and go to T1.
- T1:
  - BUS_ALE=1 and BUS_ADDR = current byte address.
  - BHE_N/A0 encoding:
    - Even word: BHE_N=0, A0=0.
    - Even byte: BHE_N=1, A0=0.
    - Odd byte, or either half of a split word: BHE_N=0, A0=1 for the odd half; BHE_N=1, A0=0 for the even half.
- T2:
  - ALE=0.
  - Read: RD_N=0.
  - Write: WR_N=0, WDATA_OE=1, and BUS_WDATA driven. A byte is replicated on both lanes; a full word is driven as-is.
- T3:
  - If BUS_READY=1: capture data and go to T4.
  - Otherwise: go to TW.
- TW: repeat until BUS_READY=1, then capture data and go to T4.
- Read data capture by lane:
  - Even address: low lane [7:0].
  - Odd address: high lane [15:8].
  - Aligned word: all 16 bits.
- T4:
  - Strobes inactive and WDATA_OE=0.
  - If a split second half is pending: increment the address modulo 2^20 and go to T1.
  - Otherwise: RSP_VALID=1 for this cycle only, RSP_RDATA valid, and go to IDLE.
- Split odd word: first cycle transfers the low data byte at A on the high lane; second cycle transfers the high data byte at A+1 on the low lane. Address 20'hFFFFF wraps to 20'h00000.
- Latency with zero wait states:
  - 4 cycles after acceptance for a single cycle.
  - 8 cycles for a split word.
  - Each TW adds 1 cycle.
  - Minimum request spacing is 5 cycles (IDLE + 4).
- RSP_RDATA holds its value until the next completion. REQ_* inputs are ignored outside IDLE.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A counter clears in T3 and increments each TW cycle.
  - When TIMEOUT_CYC TW cycles have elapsed with READY still 0, go to T4 and skip any pending second half.
  - Completion then gives RSP_VALID=1, RSP_ERR=1, RSP_RDATA=16'hFFFF.
- BUS_TIMEOUT_EN undefined:
  - TW waits indefinitely.
  - RSP_ERR is tied to 0, no counter logic exists, and TIMEOUT_CYC is unused.

Decomposition:
- Shared package bus_ciclo_pkg holds:
  - State encodings (IDLE..T4, 3 bits).
  - Lane constants LANE_LO and LANE_HI.
  - RDATA_ERR = 16'hFFFF.
- One sub-module, bus_carril_sel (combinational byte-lane steering):
  - Inputs: addr[0], word, split-phase.
  - Outputs: BHE_N, write-data lane replication, read-data extract/merge.

Test Plan:
- Aligned word read at 20'h12344, READY=1 → ALE in cycle 1, RD_N low in cycles 2-3, RSP_VALID in cycle 4 with RSP_RDATA = BUS_RDATA = 16'hBEEF, BHE_N=0.
- Odd word read at 20'h12345, memory {12345:8'h34, 12346:8'h12} → two cycles with addresses 12345 then 12346, BHE_N 0 then 1, RSP_RDATA=16'h1234 at cycle 8.
- Byte write 8'hA5 at 20'h00011 → single cycle, BHE_N=0, A0=1, BUS_WDATA=16'hA5A5, WR_N low in T2-T3, WDATA_OE=1 in T2-T3 only.
- Word read at 20'hFFFFF → second cycle at 20'h00000; with READY held low for 3 cycles in the first half → 3 TW cycles, RSP_VALID at cycle 11.
- BUS_TIMEOUT_EN with TIMEOUT_CYC=4 and READY stuck at 0 → T4 after 4 TW cycles, RSP_ERR=1, RSP_RDATA=16'hFFFF, no second half, REQ_READY=1 on the next cycle.
- RST_N pulsed low during TW → RD_N=1 and ALE=0 asynchronously, no RSP_VALID, REQ_READY=1 after release.

Source files
------------

// File: rtl/bus_ciclo_pkg.sv
// Shared definitions for the 8086-style bus-cycle controller: state encoding,
// byte-lane identifiers and the read data returned on a timed-out access.
package bus_ciclo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_TW   = 3'd4,
    ST_T4   = 3'd5
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  localparam logic [15:0] RDATA_ERR = 16'hFFFF;

endpackage

// File: rtl/bus_carril_sel.sv
// Combinational byte-lane steering: BHE_N generation, write-data lane
// replication and read-data extraction/merge for one bus cycle.
module bus_carril_sel
  import bus_ciclo_pkg::*;
(
  input  logic        a0,
  input  logic        word,
  input  logic        split,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  input  logic [7:0]  acc_lo,
  output logic        bhe_n,
  output logic [15:0] lane_wdata,
  output logic [15:0] rdata_merged
);

  logic       lane;
  logic [7:0] byte_rd;

  always_comb begin
    lane    = a0 ? LANE_HI : LANE_LO;
    byte_rd = (lane == LANE_HI) ? rdata[15:8] : rdata[7:0];
    bhe_n   = ~(a0 | (word & ~split));
    if (word && !split) begin
      lane_wdata   = wdata;
      rdata_merged = rdata;
    end else if (split && !a0) begin
      // Second half of a split word: high data byte travels on the low lane.
      lane_wdata   = {2{wdata[15:8]}};
      rdata_merged = {byte_rd, acc_lo};
    end else begin
      lane_wdata   = {2{wdata[7:0]}};
      rdata_merged = {8'h00, byte_rd};
    end
  end

endmodule

// File: rtl/bus_ciclo_8086.sv
// 8086-style T1-T2-T3-(TW)-T4 bus-cycle controller with odd-word splitting.
// Define BUS_TIMEOUT_EN to abort wait states after TIMEOUT_CYC TW cycles.
module bus_ciclo_8086
  import bus_ciclo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  // Request handshake: accepted on a rising edge where req_valid && req_ready.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_word,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [19:0] bus_addr,
  output logic        bus_bhe_n,
  output logic        bus_ale,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic [15:0] bus_wdata,
  output logic        bus_wdata_oe,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ready,
  output logic [2:0]  dbg_state
);

  state_t      state_q, state_d;
  logic [19:0] addr_inc;
  logic        wr_q, word_q, split_q, half_q, pend_q;
  logic [15:0] wdata_q;
  logic [7:0]  acc_lo_q;
  logic        accept, capture, abort, finish_half, pend_d, strobe_d;
  logic        ctx_a0, ctx_word, ctx_split;
  logic        sel_bhe_n;
  logic [15:0] sel_wdata, sel_rdata;

  assign accept      = (state_q == ST_IDLE) && req_valid;
  assign addr_inc    = bus_addr + 20'd1;
  assign capture     = ((state_q == ST_T3) || (state_q == ST_TW)) && bus_ready;
  assign finish_half = capture || abort;
  assign pend_d      = split_q && !half_q && !abort;
  assign strobe_d    = (state_d == ST_T2) || (state_d == ST_T3) || (state_d == ST_TW);
  assign dbg_state   = state_q;

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tw_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tw_cnt_q <= '0;
    else if (state_q == ST_T3)  tw_cnt_q <= '0;
    else if (state_q == ST_TW)  tw_cnt_q <= tw_cnt_q + 16'd1;
  end

  assign abort = (state_q == ST_TW) && !bus_ready && (tw_cnt_q == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign abort          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Lane context for the cycle being entered: the new request from IDLE,
  // the incremented address from T4, otherwise the cycle in progress.
  always_comb begin
    ctx_a0    = bus_addr[0];
    ctx_word  = word_q;
    ctx_split = split_q;
    if (state_q == ST_IDLE) begin
      ctx_a0    = req_addr[0];
      ctx_word  = req_word;
      ctx_split = req_word & req_addr[0];
    end else if (state_q == ST_T4) begin
      ctx_a0 = addr_inc[0];
    end
  end

  bus_carril_sel u_sel (
    .a0           (ctx_a0),
    .word         (ctx_word),
    .split        (ctx_split),
    .wdata        (wdata_q),
    .rdata        (bus_rdata),
    .acc_lo       (acc_lo_q),
    .bhe_n        (sel_bhe_n),
    .lane_wdata   (sel_wdata),
    .rdata_merged (sel_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = bus_ready ? ST_T4 : ST_TW;
      ST_TW:   if (finish_half) state_d = ST_T4;
      ST_T4:   state_d = pend_q ? ST_T1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= 1'b0;
      word_q       <= 1'b0;
      split_q      <= 1'b0;
      half_q       <= 1'b0;
      pend_q       <= 1'b0;
      wdata_q      <= '0;
      acc_lo_q     <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      bus_addr     <= '0;
      bus_bhe_n    <= 1'b1;
      bus_ale      <= 1'b0;
      bus_rd_n     <= 1'b1;
      bus_wr_n     <= 1'b1;
      bus_wdata    <= '0;
      bus_wdata_oe <= 1'b0;
    end else begin
      if (accept) begin
        wr_q     <= req_wr;
        word_q   <= req_word;
        split_q  <= req_word & req_addr[0];
        half_q   <= 1'b0;
        wdata_q  <= req_wdata;
        bus_addr <= req_addr;
      end
      if ((state_q == ST_T4) && pend_q) begin
        bus_addr <= addr_inc;
        half_q   <= 1'b1;
      end
      if (capture)     acc_lo_q <= sel_rdata[7:0];
      if (finish_half) pend_q   <= pend_d;

      rsp_valid <= finish_half && !pend_d;
      rsp_err   <= finish_half && abort;
      if (finish_half && !pend_d) begin
        if (abort)      rsp_rdata <= RDATA_ERR;
        else if (!wr_q) rsp_rdata <= sel_rdata;
      end

      req_ready    <= (state_d == ST_IDLE);
      bus_ale      <= (state_d == ST_T1);
      bus_rd_n     <= !(strobe_d && !wr_q);
      bus_wr_n     <= !(strobe_d && wr_q);
      bus_wdata_oe <= strobe_d && wr_q;
      if (state_d == ST_T1)        bus_bhe_n <= sel_bhe_n;
      else if (state_d == ST_IDLE) bus_bhe_n <= 1'b1;
      if ((state_q == ST_T1) && wr_q) bus_wdata <= sel_wdata;
    end
  end

endmodule

// File: tb/tb_bus_ciclo_8086.sv
// Self-checking bench for bus_ciclo_8086: directed bus-cycle scenarios plus
// random requests against a byte-addressed reference memory.
module tb_bus_ciclo_8086;

  localparam int TO_CYC = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wr, req_word;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [19:0] bus_addr;
  logic        bus_bhe_n, bus_ale, bus_rd_n, bus_wr_n, bus_wdata_oe;
  logic [15:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Bus-side memory (written only through the bus pins) and request-level reference.
  logic [7:0] bmem    [0:1048575];
  logic [7:0] ref_mem [0:1048575];

  int wq[$];
  int ph = 0;
  int cur_w = 0;

  logic        tr_ale  [64];
  logic        tr_rd_n [64];
  logic        tr_wr_n [64];
  logic        tr_oe   [64];
  logic        tr_bhe  [64];
  logic [19:0] tr_addr [64];
  logic [15:0] tr_wdata[64];

  bus_ciclo_8086 #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_word     (req_word),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bus_addr     (bus_addr),
    .bus_bhe_n    (bus_bhe_n),
    .bus_ale      (bus_ale),
    .bus_rd_n     (bus_rd_n),
    .bus_wr_n     (bus_wr_n),
    .bus_wdata    (bus_wdata),
    .bus_wdata_oe (bus_wdata_oe),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and wait-state responder: acts on the bus pins at the falling edge.
  always @(negedge clk) begin
    if (!bus_wr_n) begin
      if (!bus_addr[0]) bmem[{bus_addr[19:1], 1'b0}] = bus_wdata[7:0];
      if (!bus_bhe_n)   bmem[{bus_addr[19:1], 1'b1}] = bus_wdata[15:8];
    end
    if (bus_ale) begin
      ph    = 1;
      cur_w = (wq.size() > 0) ? wq.pop_front() : 0;
    end else if (ph != 0) begin
      ph++;
    end
    bus_ready = !((ph >= 3) && (ph < 3 + cur_w));
    bus_rdata = {bmem[{bus_addr[19:1], 1'b1}], bmem[{bus_addr[19:1], 1'b0}]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver + scoreboard for one request; w0/w1 are wait states per half.
  task automatic do_req(input logic wr, input logic word, input logic [19:0] addr,
                        input logic [15:0] wdata, input int w0, input int w1,
                        input logic exp_abort);
    logic        split, seen;
    logic [19:0] a1;
    logic [15:0] exp_rd;
    int          exp_lat, lat;
    split = word & addr[0];
    a1    = addr + 20'd1;
    wq.delete();
    wq.push_back(w0);
    if (split) wq.push_back(w1);
    if (exp_abort) begin
      exp_rd  = 16'hFFFF;
      exp_lat = 4 + TO_CYC;
    end else begin
      exp_rd  = word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
      exp_lat = (split ? 8 + w0 + w1 : 4 + w0);
      if (wr) begin
        ref_mem[addr] = wdata[7:0];
        if (word) ref_mem[a1] = wdata[15:8];
      end
    end
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_word  = word;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c < 64 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      tr_ale[c]   = bus_ale;
      tr_rd_n[c]  = bus_rd_n;
      tr_wr_n[c]  = bus_wr_n;
      tr_oe[c]    = bus_wdata_oe;
      tr_bhe[c]   = bus_bhe_n;
      tr_addr[c]  = bus_addr;
      tr_wdata[c] = bus_wdata;
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("rsp_seen", seen, 1);
    check("latency", lat, exp_lat);
    check("rsp_err", rsp_err, exp_abort);
    check("t1_ale", tr_ale[1], 1);
    check("t1_addr", tr_addr[1], addr);
    check("t1_bhe_n", tr_bhe[1], !(addr[0] || word));
    if (!wr || exp_abort) check("rsp_rdata", rsp_rdata, exp_rd);
    if (wr && !exp_abort) begin
      check("mem_lo", bmem[addr], ref_mem[addr]);
      if (word) check("mem_hi", bmem[a1], ref_mem[a1]);
    end
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  initial begin
    logic any_rsp;
    logic [19:0] ra;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_word  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    bus_ready = 1'b1;
    bus_rdata = '0;
    for (int i = 0; i < 1048576; i++) begin
      bmem[i]    = 8'($urandom);
      ref_mem[i] = bmem[i];
    end

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd_n", bus_rd_n, 1);
    check("rst_wr_n", bus_wr_n, 1);
    check("rst_bhe_n", bus_bhe_n, 1);
    check("rst_ale", bus_ale, 0);
    check("rst_oe", bus_wdata_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word read, no wait states
    bmem[20'h12344] = 8'hEF; ref_mem[20'h12344] = 8'hEF;
    bmem[20'h12345] = 8'hBE; ref_mem[20'h12345] = 8'hBE;
    do_req(1'b0, 1'b1, 20'h12344, 16'h0000, 0, 0, 1'b0);
    check("aw_rdata", rsp_rdata, 16'hBEEF);
    check("aw_rd_c1", tr_rd_n[1], 1);
    check("aw_rd_c2", tr_rd_n[2], 0);
    check("aw_rd_c3", tr_rd_n[3], 0);
    check("aw_rd_c4", tr_rd_n[4], 1);
    check("aw_ale_c2", tr_ale[2], 0);

    // Odd word read split into two byte cycles
    bmem[20'h12345] = 8'h34; ref_mem[20'h12345] = 8'h34;
    bmem[20'h12346] = 8'h12; ref_mem[20'h12346] = 8'h12;
    do_req(1'b0, 1'b1, 20'h12345, 16'h0000, 0, 0, 1'b0);
    check("ow_rdata", rsp_rdata, 16'h1234);
    check("ow_addr2", tr_addr[5], 20'h12346);
    check("ow_ale2", tr_ale[5], 1);
    check("ow_bhe2", tr_bhe[5], 1);

    // Odd byte write
    do_req(1'b1, 1'b0, 20'h00011, 16'h00A5, 0, 0, 1'b0);
    check("bw_wdata", tr_wdata[2], 16'hA5A5);
    check("bw_wr_c2", tr_wr_n[2], 0);
    check("bw_wr_c3", tr_wr_n[3], 0);
    check("bw_wr_c4", tr_wr_n[4], 1);
    check("bw_oe_c1", tr_oe[1], 0);
    check("bw_oe_c2", tr_oe[2], 1);
    check("bw_oe_c3", tr_oe[3], 1);
    check("bw_oe_c4", tr_oe[4], 0);
    check("bw_mem", bmem[20'h00011], 8'hA5);
    check("bw_neighbor", bmem[20'h00010], ref_mem[20'h00010]);

    // Word read wrapping the top of the address space, 3 waits in the first half
    do_req(1'b0, 1'b1, 20'hFFFFF, 16'h0000, 3, 0, 1'b0);
    check("wrap_addr2", tr_addr[8], 20'h00000);
    check("wrap_ale2", tr_ale[8], 1);

`ifdef BUS_TIMEOUT_EN
    // Stuck READY aborts after TO_CYC wait states and drops the second half
    do_req(1'b0, 1'b1, 20'h20001, 16'h0000, 1000, 0, 1'b1);
    any_rsp = 1'b0;
    for (int c = 2; c <= 4 + TO_CYC; c++) if (tr_ale[c]) any_rsp = 1'b1;
    check("to_no_second_half", any_rsp, 0);
`endif

    // Reset pulsed during a wait state
    wq.delete();
    wq.push_back(20);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_word = 1'b0; req_addr = 20'h00400;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("rt_in_wait", bus_rd_n, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rt_rd_n", bus_rd_n, 1);
    check("rt_ale", bus_ale, 0);
    check("rt_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_rsp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) any_rsp = 1'b1;
    end
    check("rt_no_rsp", any_rsp, 0);
    check("rt_ready", req_ready, 1);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 5) == 0) ? 20'hFFFFF : 20'($urandom);
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
             16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
